alu_pipe: RTL and testbench
===========================

# alu_pipe

Registered, handshaked successor to the combinational ALU: same opcode map and flag meanings, generalised to any `BUS_WIDTH`. It adds a stored carry flag, OR/XOR, and a multi-cycle shift-add multiply. It sits between an operand source and a result consumer, with valid/ready on both sides, so it can be dropped into a datapath pipeline.

## Interface
- `BUS_WIDTH`, default 8: operand/result width, must be ≥ 2.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: operand/opcode presented.
- `in_ready` output 1: block accepts an operation this cycle.
- `a`, `b` input BUS_WIDTH: operands.
- `opcode` input 4: operation select.
- `out_valid` output 1: result registers hold a result.
- `out_ready` input 1: consumer takes the result.
- `y` output BUS_WIDTH: result.
- `carry_out`, `borrow`, `zero`, `parity`, `invalid_op` output 1 each: result flags.
- `carry_flag` output 1: stored carry, used by ADD_CARRY.

## Operation
- Opcodes:
  - 1 ADD: {carry_out,y}=a+b.
  - 2 ADD_CARRY: {carry_out,y}=a+b+carry_flag.
  - 3 SUB: {borrow,y}=a−b.
  - 4 INC: {carry_out,y}=a+1.
  - 5 DEC: {borrow,y}=a−1.
  - 6 AND: a&b.
  - 7 NOT: ~a.
  - 8 ROL: rotate a left 1.
  - 9 ROR: rotate a right 1.
  - 10 OR: a|b.
  - 11 XOR: a^b.
  - 12 MUL: y = low BUS_WIDTH bits of a*b; carry_out=1 iff the high half is nonzero.
- Opcodes 0 and 13–15 are invalid: y=0, invalid_op=1, all other flags 0 except zero=1.
- Flags not named for an opcode are 0.
- zero = (y==0) and parity = ^y, both taken from the registered y, so they are consistent with y on every cycle.
- carry_flag update, on result load only:
  - carry_out for ADD, ADD_CARRY, INC, MUL.
  - borrow for SUB, DEC.
  - unchanged for all other opcodes, including invalid ones.
- State machine:
  - IDLE: accept when in_valid && in_ready.
    - If MUL, go to MUL with count=0.
    - Otherwise load the result regs and stay in IDLE.
  - MUL: one shift-add step per cycle. After BUS_WIDTH steps, load the result regs and return to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- out_valid: set on result load; cleared on out_ready when no new load occurs in the same cycle.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, out_valid=0, y=0, all flags=0, carry_flag=0. This applies from the next cycle, so in_ready=1 is seen the first cycle after rst_n returns high.
- Single-cycle ops: result and out_valid appear 1 cycle after acceptance. Throughput is 1 per cycle while out_ready=1.
- MUL: out_valid appears BUS_WIDTH+1 cycles after acceptance. in_ready=0 throughout; carry_flag is not touched until the load.
- Backpressure: while out_valid=1 and out_ready=0, y, flags and carry_flag hold stable and in_ready=0.
- Simultaneous out_ready=1 and acceptance in the same cycle: the old result retires and the new result loads at the next edge, so out_valid stays 1.
- ADD_CARRY accepted directly after a carry-producing op uses the updated carry_flag; the update is visible in the acceptance cycle.
- Reset during MUL aborts the multiply: no result is produced and carry_flag=0.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams OP_ADD … OP_MUL, values 1–12;
  - a 2-state enum IDLE/MUL;
  - a function returning whether an opcode is valid.
- Sub-module `alu_mul_seq`: sequential shift-add multiplier with start/done, parameterised by BUS_WIDTH, producing a 2·BUS_WIDTH product.
- The combinational single-cycle datapath stays inline in `alu_pipe`.

## Test plan
All scenarios use BUS_WIDTH=8.
- ADD a=0xFF, b=0x01 → 1 cycle later y=0x00, carry_out=1, zero=1, parity=0, carry_flag=1. Then ADD_CARRY a=0x10, b=0x20 → y=0x31, carry_out=0, carry_flag=0.
- SUB a=0x05, b=0x06 → y=0xFF, borrow=1, parity=0, carry_flag=1. Then DEC a=0x00 → y=0xFF, borrow=1.
- MUL a=0x12, b=0x10 → in_ready=0 for 8 cycles, out_valid on cycle 9 after acceptance, y=0x20, carry_out=1, carry_flag=1.
- Back-to-back AND/OR/XOR/ROL/ROR with a=0x81, b=0x0F and out_ready=1 → one result per cycle: 0x01, 0x8F, 0x8E, 0x03, 0xC0.
- Backpressure: hold out_ready=0 for 3 cycles after a result with in_valid=1 → y/flags stable, in_ready=0, nothing accepted. On release, the pending op is accepted the same cycle.
- Opcode 0 and opcode 15 → invalid_op=1, y=0, zero=1, carry_flag unchanged.
- Reset: rst_n=0 on cycle 4 of a MUL → next cycle out_valid=0, carry_flag=0; no result appears after rst_n returns high.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, state encoding and opcode check for alu_pipe
//
// Purpose: common definitions used by alu_pipe and its testbench.
// Contents: OP_* opcode constants (1..12), state_t (IDLE/MUL), op_is_valid().
package alu_pkg;

    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_ROL       = 4'd8;
    localparam logic [3:0] OP_ROR       = 4'd9;
    localparam logic [3:0] OP_OR        = 4'd10;
    localparam logic [3:0] OP_XOR       = 4'd11;
    localparam logic [3:0] OP_MUL       = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential shift-add multiplier, one partial product per cycle
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           load operands a/b and begin (ignored-state restart)
//   a, b            BUS_WIDTH-bit operands
//   done            high in the cycle the final step is applied
//   product         2*BUS_WIDTH-bit product; valid while done is high
module alu_mul_seq #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BUS_WIDTH-1:0]   a,
    input  logic [BUS_WIDTH-1:0]   b,
    output logic                   done,
    output logic [2*BUS_WIDTH-1:0] product
);

    localparam int CW = $clog2(BUS_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(BUS_WIDTH - 1);

    logic                   busy;
    logic [CW-1:0]          count;
    logic [2*BUS_WIDTH-1:0] acc;
    logic [2*BUS_WIDTH-1:0] mcand;
    logic [BUS_WIDTH-1:0]   mplier;
    logic [2*BUS_WIDTH-1:0] step_acc;

    // Accumulator after this cycle's step; on the last step this is the
    // finished product, so the caller can capture it at the same edge.
    assign step_acc = mplier[0] ? (acc + mcand) : acc;
    assign product  = step_acc;
    assign done     = busy && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{BUS_WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= step_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with stored carry and sequential multiply
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid, in_ready         operation handshake (a, b, opcode)
//   out_valid, out_ready       result handshake (y and flags)
//   y                          BUS_WIDTH-bit result
//   carry_out, borrow, zero,
//   parity, invalid_op         result flags, registered with y
//   carry_flag                 stored carry consumed by ADD_CARRY
module alu_pipe
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 zero,
    output logic                 parity,
    output logic                 invalid_op,
    output logic                 carry_flag
);

    state_t state, state_next;

    logic                   accept;
    logic                   mul_start;
    logic                   mul_done;
    logic [2*BUS_WIDTH-1:0] mul_product;
    logic                   load;

    logic [BUS_WIDTH-1:0]   res_y;
    logic                   res_c, res_b, res_inv;
    logic [BUS_WIDTH-1:0]   ld_y;
    logic                   ld_c, ld_b, ld_inv, ld_cf;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);
    assign load      = (accept && (opcode != OP_MUL)) || ((state == MUL) && mul_done);

    alu_mul_seq #(.BUS_WIDTH(BUS_WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath. MUL falls to default here but is never loaded
    // from this path; it is steered from the multiplier below.
    always_comb begin
        res_y   = '0;
        res_c   = 1'b0;
        res_b   = 1'b0;
        res_inv = 1'b0;
        case (opcode)
            OP_ADD:       {res_c, res_y} = {1'b0, a} + {1'b0, b};
            OP_ADD_CARRY: {res_c, res_y} = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_flag};
            OP_SUB:       {res_b, res_y} = {1'b0, a} - {1'b0, b};
            OP_INC:       {res_c, res_y} = {1'b0, a} + (BUS_WIDTH+1)'(1);
            OP_DEC:       {res_b, res_y} = {1'b0, a} - (BUS_WIDTH+1)'(1);
            OP_AND:       res_y = a & b;
            OP_NOT:       res_y = ~a;
            OP_ROL:       res_y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
            OP_ROR:       res_y = {a[0], a[BUS_WIDTH-1:1]};
            OP_OR:        res_y = a | b;
            OP_XOR:       res_y = a ^ b;
            default:      res_inv = !op_is_valid(opcode);
        endcase
    end

    // Select what gets loaded into the result registers and the new stored carry.
    always_comb begin
        ld_y   = res_y;
        ld_c   = res_c;
        ld_b   = res_b;
        ld_inv = res_inv;
        ld_cf  = carry_flag;
        if (state == MUL) begin
            ld_y   = mul_product[BUS_WIDTH-1:0];
            ld_c   = |mul_product[2*BUS_WIDTH-1:BUS_WIDTH];
            ld_b   = 1'b0;
            ld_inv = 1'b0;
            ld_cf  = ld_c;
        end else begin
            case (opcode)
                OP_ADD, OP_ADD_CARRY, OP_INC: ld_cf = res_c;
                OP_SUB, OP_DEC:               ld_cf = res_b;
                default:                      ld_cf = carry_flag;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // zero/parity are computed from the value being loaded so they always
    // describe the y register they sit beside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            y          <= '0;
            carry_out  <= 1'b0;
            borrow     <= 1'b0;
            zero       <= 1'b0;
            parity     <= 1'b0;
            invalid_op <= 1'b0;
            carry_flag <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            y          <= ld_y;
            carry_out  <= ld_c;
            borrow     <= ld_b;
            zero       <= (ld_y == '0);
            parity     <= ^ld_y;
            invalid_op <= ld_inv;
            carry_flag <= ld_cf;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (BUS_WIDTH=8)
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       carry_out, borrow, zero, parity, invalid_op, carry_flag;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.BUS_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .carry_out  (carry_out),
        .borrow     (borrow),
        .zero       (zero),
        .parity     (parity),
        .invalid_op (invalid_op),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y: got %h want 00", y); end
        total++; if ({carry_out, borrow, zero, parity, invalid_op, carry_flag} !== 6'b0)
            begin bad++; $display("FAIL reset_flags: got %b want 000000", {carry_out, borrow, zero, parity, invalid_op, carry_flag}); end
    endtask

    task automatic test_add();
        issue(OP_ADD, 8'hFF, 8'h01);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
        total++; if (y !== 8'h00) begin bad++; $display("FAIL add_y: got %h want 00", y); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL add_carry_out: got %b want 1", carry_out); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL add_zero: got %b want 1", zero); end
        total++; if (parity !== 1'b0) begin bad++; $display("FAIL add_parity: got %b want 0", parity); end
        total++; if (carry_flag !== 1'b1) begin bad++; $display("FAIL add_carry_flag: got %b want 1", carry_flag); end
        issue(OP_ADD_CARRY, 8'h10, 8'h20);
        total++; if (y !== 8'h31) begin bad++; $display("FAIL adc_y: got %h want 31", y); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL adc_carry_out: got %b want 0", carry_out); end
        total++; if (carry_flag !== 1'b0) begin bad++; $display("FAIL adc_carry_flag: got %b want 0", carry_flag); end
        total++; if (parity !== 1'b1) begin bad++; $display("FAIL adc_parity: got %b want 1", parity); end
    endtask

    task automatic test_sub();
        issue(OP_SUB, 8'h05, 8'h06);
        total++; if (y !== 8'hFF) begin bad++; $display("FAIL sub_y: got %h want ff", y); end
        total++; if (borrow !== 1'b1) begin bad++; $display("FAIL sub_borrow: got %b want 1", borrow); end
        total++; if (parity !== 1'b0) begin bad++; $display("FAIL sub_parity: got %b want 0", parity); end
        total++; if (carry_flag !== 1'b1) begin bad++; $display("FAIL sub_carry_flag: got %b want 1", carry_flag); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL sub_carry_out: got %b want 0", carry_out); end
        issue(OP_DEC, 8'h00, 8'h00);
        total++; if (y !== 8'hFF) begin bad++; $display("FAIL dec_y: got %h want ff", y); end
        total++; if (borrow !== 1'b1) begin bad++; $display("FAIL dec_borrow: got %b want 1", borrow); end
        issue(OP_INC, 8'h7F, 8'h00);
        total++; if (y !== 8'h80 || carry_out !== 1'b0 || carry_flag !== 1'b0)
            begin bad++; $display("FAIL inc: got y=%h c=%b cf=%b want y=80 c=0 cf=0", y, carry_out, carry_flag); end
    endtask

    task automatic test_mul();
        issue(OP_ADD, 8'h01, 8'h01);
        issue(OP_MUL, 8'h12, 8'h10);
        for (int k = 1; k <= 8; k++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || carry_flag !== 1'b0)
                begin bad++; $display("FAIL mul_busy_c%0d: got rdy=%b vld=%b cf=%b want 0 0 0", k, in_ready, out_valid, carry_flag); end
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_valid: got %b want 1", out_valid); end
        total++; if (y !== 8'h20) begin bad++; $display("FAIL mul_y: got %h want 20", y); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL mul_carry_out: got %b want 1", carry_out); end
        total++; if (carry_flag !== 1'b1) begin bad++; $display("FAIL mul_carry_flag: got %b want 1", carry_flag); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops  [5];
        logic [7:0] exps [5];
        ops  = '{OP_AND, OP_OR, OP_XOR, OP_ROL, OP_ROR};
        exps = '{8'h01, 8'h8F, 8'h8E, 8'h03, 8'hC0};
        out_ready = 1'b1;
        a = 8'h81; b = 8'h0F;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i];
            tick();
            total++; if (out_valid !== 1'b1 || y !== exps[i])
                begin bad++; $display("FAIL b2b_%0d: got vld=%b y=%h want vld=1 y=%h", i, out_valid, y, exps[i]); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        issue(OP_ADD, 8'h03, 8'h04);
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = OP_OR; a = 8'hF0; b = 8'h0F;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'h07 || parity !== 1'b1 || zero !== 1'b0)
                begin bad++; $display("FAIL bp_hold_%0d: got rdy=%b vld=%b y=%h p=%b z=%b want 0 1 07 1 0", k, in_ready, out_valid, y, parity, zero); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || y !== 8'hFF)
            begin bad++; $display("FAIL bp_release_result: got vld=%b y=%h want 1 ff", out_valid, y); end
    endtask

    task automatic test_invalid();
        issue(OP_ADD, 8'hFF, 8'h01);
        issue(4'd0, 8'h55, 8'h33);
        total++; if (invalid_op !== 1'b1 || y !== 8'h00 || zero !== 1'b1)
            begin bad++; $display("FAIL inv0: got inv=%b y=%h z=%b want 1 00 1", invalid_op, y, zero); end
        total++; if (carry_flag !== 1'b1 || carry_out !== 1'b0 || borrow !== 1'b0 || parity !== 1'b0)
            begin bad++; $display("FAIL inv0_flags: got cf=%b c=%b bw=%b p=%b want 1 0 0 0", carry_flag, carry_out, borrow, parity); end
        issue(OP_ADD, 8'h01, 8'h01);
        issue(4'd15, 8'hAA, 8'hAA);
        total++; if (invalid_op !== 1'b1 || y !== 8'h00 || zero !== 1'b1 || carry_flag !== 1'b0)
            begin bad++; $display("FAIL inv15: got inv=%b y=%h z=%b cf=%b want 1 00 1 0", invalid_op, y, zero, carry_flag); end
        issue(OP_NOT, 8'h0F, 8'h00);
        total++; if (invalid_op !== 1'b0 || y !== 8'hF0)
            begin bad++; $display("FAIL not: got inv=%b y=%h want 0 f0", invalid_op, y); end
    endtask

    task automatic test_reset_mul();
        int seen;
        issue(OP_ADD, 8'hFF, 8'h01);
        issue(OP_MUL, 8'h12, 8'h10);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || carry_flag !== 1'b0)
            begin bad++; $display("FAIL rstmul_state: got vld=%b cf=%b want 0 0", out_valid, carry_flag); end
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmul_no_result: got %0d valid cycles want 0", seen); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmul_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_invalid();
        test_reset_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1);
    end

endmodule
